// File: rtl/div_pkg.sv
// div_pkg: shared width, FSM state encoding and divide-by-zero quotient for the divider
package div_pkg;
    localparam int DIV_WIDTH = 16;
    localparam logic [DIV_WIDTH-1:0] DZ_QUOT = 16'hFFFF;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);
    logic [WIDTH:0] sh;
    // keep the difference only when the shifted remainder covers the divisor; otherwise restore
    always_comb begin
        sh = {rem, din};
        qbit = sh >= {1'b0, dvs};
        rem_nxt = qbit ? sh[WIDTH-1:0] - dvs : sh[WIDTH-1:0];
    end
endmodule

// File: rtl/div.sv
// div: sequential restoring divider, one quotient bit per clock; DIV_SIGNED_EN adds SGN two's-complement mode
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIV_SIGNED_EN
    input  logic             SGN,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic             DZ,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nxt;
    logic [WIDTH-1:0] rem, dvd, dvs, rem_nxt, a_mag, b_mag, quo;
    logic [CW-1:0] cnt;
    logic qbit, zb, accept, last, neg_a, neg_b, neg_q, neg_r;

`ifdef DIV_SIGNED_EN
    assign neg_a = SGN & A[WIDTH-1];
    assign neg_b = SGN & B[WIDTH-1];
    // remember result signs at capture: quotient negative on sign mismatch, remainder follows A
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
        end
    end
`else
    assign neg_a = 1'b0;
    assign neg_b = 1'b0;
    assign neg_q = 1'b0;
    assign neg_r = 1'b0;
`endif

    assign a_mag  = neg_a ? -A : A;
    assign b_mag  = neg_b ? -B : B;
    assign accept = START && state != S_RUN;
    assign last   = state == S_RUN && cnt == '0;
    assign quo    = {dvd[WIDTH-2:0], qbit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .din     (dvd[WIDTH-1]),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next state: START wins outside RUN, RUN ends on the last step, DONE lasts one cycle
    always_comb begin
        state_nxt = accept ? S_RUN : last ? S_DONE : state == S_RUN ? S_RUN : S_IDLE;
    end

    // status outputs decoded from state
    always_comb begin
        BUSY = state == S_RUN;
        DONE = state == S_DONE;
    end

    // datapath: capture magnitudes, iterate the step, register signed-corrected results on the last step
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem <= '0;
            dvd <= '0;
            dvs <= '0;
            cnt <= '0;
            zb  <= 1'b0;
            DZ  <= 1'b0;
            HI  <= '0;
            LO  <= '0;
        end else if (accept) begin
            rem <= '0;
            dvd <= a_mag;
            dvs <= b_mag;
            cnt <= CW'(WIDTH - 1);
            zb  <= B == '0;
        end else if (state == S_RUN) begin
            rem <= rem_nxt;
            dvd <= quo;
            cnt <= cnt - CW'(1);
            if (last) begin
                HI <= neg_r ? -rem_nxt : rem_nxt;
                LO <= zb ? WIDTH'(DZ_QUOT) : neg_q ? -quo : quo;
                DZ <= zb;
            end
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against an arithmetic reference model
module tb_div;
    logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, SGN = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic BUSY, DONE, DZ;
    logic [15:0] HI, LO;
    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    div dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
`ifdef DIV_SIGNED_EN
        .SGN   (SGN),
`endif
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DZ    (DZ),
        .HI    (HI),
        .LO    (LO)
    );

    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int ai, bi;
        logic [15:0] q, r;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
        end else if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
            q = 16'(ai / bi);
            r = 16'(ai % bi);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {b == 16'd0, r, q};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        @(negedge CLK);
        A = a; B = b; SGN = s; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = 16'($urandom); B = 16'($urandom); SGN = ~s;
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, DZ, HI, LO} !== 35'd0) begin
            failures++;
            $display("FAIL reset: got %h want 0", {BUSY, DONE, DZ, HI, LO});
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run_op(16'd100, 16'd7, 1'b0, lat);
        checks++;
        if (lat !== 16) begin failures++; $display("FAIL basic_latency: got %0d want 16", lat); end
        checks++;
        if ({DZ, HI, LO} !== {1'b0, 16'd2, 16'd14}) begin
            failures++; $display("FAIL basic_result: got %h want %h", {DZ, HI, LO}, {1'b0, 16'd2, 16'd14});
        end
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done: got %b want 0", BUSY); end
    endtask

    task automatic test_div_zero;
        int lat;
        run_op(16'h1234, 16'd0, 1'b0, lat);
        checks++;
        if ({DZ, HI, LO} !== {1'b1, 16'h1234, 16'hFFFF} || lat !== 16) begin
            failures++; $display("FAIL dz_result: got %h lat %0d want %h lat 16", {DZ, HI, LO}, lat, {1'b1, 16'h1234, 16'hFFFF});
        end
        run_op(16'd9, 16'd3, 1'b0, lat);
        checks++;
        if ({DZ, HI, LO} !== {1'b0, 16'd0, 16'd3}) begin
            failures++; $display("FAIL dz_clear: got %h want %h", {DZ, HI, LO}, {1'b0, 16'd0, 16'd3});
        end
    endtask

    task automatic test_back_to_back;
        int lat, n;
        run_op(16'hFFFF, 16'd1, 1'b0, lat);
        checks++;
        if ({DZ, HI, LO} !== {1'b0, 16'd0, 16'hFFFF} || lat !== 16) begin
            failures++; $display("FAIL b2b_first: got %h lat %0d want %h lat 16", {DZ, HI, LO}, lat, {1'b0, 16'd0, 16'hFFFF});
        end
        A = 16'd50; B = 16'd8; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = 16'($urandom); B = 16'($urandom);
        checks++;
        if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy got %b want 1", BUSY); end
        n = 1;
        while (DONE !== 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (n !== 17) begin failures++; $display("FAIL b2b_spacing: got %0d want 17", n); end
        checks++;
        if ({DZ, HI, LO} !== {1'b0, 16'd2, 16'd6}) begin
            failures++; $display("FAIL b2b_second: got %h want %h", {DZ, HI, LO}, {1'b0, 16'd2, 16'd6});
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom_range(1, 300));
        @(negedge CLK);
        A = a; B = b; SGN = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (lat == 5) begin START = 1'b1; A = ~a; B = b + 16'd7; end
            else START = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        checks++;
        if (lat !== 16) begin failures++; $display("FAIL ignore_latency: got %0d want 16", lat); end
        checks++;
        if ({DZ, HI, LO} !== model(a, b, 1'b0)) begin
            failures++; $display("FAIL ignore_result: got %h want %h", {DZ, HI, LO}, model(a, b, 1'b0));
        end
    endtask

    task automatic test_reset_mid;
        int lat, seen;
        logic [15:0] a, b;
        @(negedge CLK);
        A = 16'd1000; B = 16'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (8) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, DZ, HI, LO} !== 35'd0) begin
            failures++; $display("FAIL midreset_clear: got %h want 0", {BUSY, DONE, DZ, HI, LO});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1 || BUSY === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
        a = 16'($urandom);
        b = 16'($urandom_range(1, 1000));
        run_op(a, b, 1'b0, lat);
        checks++;
        if ({DZ, HI, LO} !== model(a, b, 1'b0) || lat !== 16) begin
            failures++; $display("FAIL midreset_restart: got %h lat %0d want %h lat 16", {DZ, HI, LO}, lat, model(a, b, 1'b0));
        end
    endtask

    task automatic test_random(input logic s, input int iters);
        int lat;
        logic [15:0] a, b;
        for (int i = 0; i < iters; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (i % 7 == 3) b = s ? 16'hFFFF : 16'd1;
            run_op(a, b, s, lat);
            checks++;
            if (lat !== 16) begin failures++; $display("FAIL random_latency: a=%h b=%h got %0d want 16", a, b, lat); end
            checks++;
            if ({DZ, HI, LO} !== model(a, b, s)) begin
                failures++; $display("FAIL random_result: a=%h b=%h s=%b got %h want %h", a, b, s, {DZ, HI, LO}, model(a, b, s));
            end
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat;
        run_op(-16'sd7, 16'd2, 1'b1, lat);
        checks++;
        if ({HI, LO} !== {16'hFFFF, 16'hFFFD}) begin
            failures++; $display("FAIL signed_neg_a: got %h want %h", {HI, LO}, {16'hFFFF, 16'hFFFD});
        end
        run_op(16'd7, -16'sd2, 1'b1, lat);
        checks++;
        if ({HI, LO} !== {16'd1, 16'hFFFD}) begin
            failures++; $display("FAIL signed_neg_b: got %h want %h", {HI, LO}, {16'd1, 16'hFFFD});
        end
        run_op(16'h8000, 16'hFFFF, 1'b1, lat);
        checks++;
        if ({DZ, HI, LO} !== {1'b0, 16'd0, 16'h8000}) begin
            failures++; $display("FAIL signed_wrap: got %h want %h", {DZ, HI, LO}, {1'b0, 16'd0, 16'h8000});
        end
        run_op(16'hFFF9, 16'd0, 1'b1, lat);
        checks++;
        if ({DZ, HI, LO} !== {1'b1, 16'hFFF9, 16'hFFFF}) begin
            failures++; $display("FAIL signed_dz: got %h want %h", {DZ, HI, LO}, {1'b1, 16'hFFF9, 16'hFFFF});
        end
        test_random(1'b1, 30);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_random(1'b0, 40);
`ifdef DIV_SIGNED_EN
        test_signed;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div.md
# div

Sequential 16-bit integer divider; the inverse companion of the datapath's single-cycle multiplier. Computes A / B by restoring division, one quotient bit per clock. Writes the quotient to LO and the remainder to HI, so the same HI/LO register pair semantics serve both multiply and divide. Sits beside the multiplier in the ALU path; the control unit starts it and stalls on BUSY.

## Interface
- WIDTH, 16, operand, quotient and remainder width; the counter and timing below are stated for 16.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- START  in  1  request a division; sampled only when not BUSY.
- A  in  16  dividend; captured with START.
- B  in  16  divisor; captured with START.
- SGN  in  1  signed mode; present only with DIV_SIGNED_EN.
- BUSY  out  1  division in progress.
- DONE  out  1  one-cycle pulse: HI/LO/DZ updated.
- DZ  out  1  last division had B == 0; held until the next completion.
- HI  out  16  remainder; held between completions.
- LO  out  16  quotient; held between completions.

## Operation
- States:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1, 16 steps, 4-bit step counter.
  - DONE: BUSY=0, DONE=1, lasts exactly one cycle, then IDLE.
- IDLE or DONE with START=1: capture A and B (magnitudes in signed mode), clear the partial remainder, counter=15, go to RUN.
- RUN step: shift {remainder, dividend} left 1; trial = remainder − divisor (17-bit). If non-negative, keep the trial value and set the quotient bit to 1; otherwise restore and set the bit to 0. On the step with counter==0, register HI/LO/DZ and go to DONE.
- START while in RUN: ignored; there is no queueing.
- B == 0: the algorithm runs normally. Result is LO=16'hFFFF, HI=A (raw input), DZ=1. No trap.
- Unsigned mode: plain 16-bit unsigned quotient and remainder.

## Timing
- Reset: state IDLE, BUSY=0, DONE=0, DZ=0, HI=0, LO=0. Any internal registers are cleared.
- START sampled at edge E0. BUSY is high after E0 through edge E16. The 16 steps execute at edges E1..E16, and HI/LO/DZ are registered at E16.
- DONE is high for the cycle following E16. Total latency from START to DONE is 16 cycles.
- Back-to-back: START asserted during the DONE cycle is accepted at E17, with no idle bubble.
- Reset asserted mid-RUN: the operation aborts immediately and outputs return to their reset values. No DONE is produced.
- A and B may change after the capture edge without affecting the result.

## Configuration
- DIV_SIGNED_EN defined:
  - The SGN port exists.
  - With SGN=1, operands are treated as two's complement. The core divides magnitudes.
  - The quotient is negated if sign(A)≠sign(B). The remainder takes the sign of A.
  - 16'h8000 / 16'hFFFF gives LO=16'h8000, HI=0 (wraps, no flag).
  - B==0 behaves the same as in unsigned mode.
- DIV_SIGNED_EN undefined: the SGN port and the sign logic are absent; the block is unsigned only.

## Structure
- Shared package div_pkg holds:
  - the WIDTH default constant;
  - the state enum (IDLE, RUN, DONE);
  - the divide-by-zero quotient constant 16'hFFFF.
- One sub-module, div_step: a combinational single restoring step. Inputs are the remainder, the next dividend bit and the divisor. Outputs are the new remainder and the quotient bit. The top level instantiates it once and iterates it over time.

## Test plan
- A=100, B=7, START for 1 cycle -> DONE exactly 16 cycles after the START edge; LO=14, HI=2, DZ=0; BUSY low during the DONE cycle.
- A=16'h1234, B=0 -> LO=16'hFFFF, HI=16'h1234, DZ=1. A following 9/3 -> LO=3, HI=0, DZ=0.
- A=16'hFFFF, B=1, then START during the DONE cycle with A=50, B=8 -> first result LO=16'hFFFF, HI=0. Second result LO=6, HI=2, with DONE 17 cycles after the first DONE.
- START pulsed at cycle 5 of RUN with different A and B -> ignored; the original result is delivered with unchanged latency.
- RST_N low at step 8 of RUN -> BUSY, DONE, DZ, HI and LO are 0 asynchronously; no DONE afterwards. A new START works normally.
- DIV_SIGNED_EN, SGN=1:
  - −7/2 -> LO=16'hFFFD, HI=16'hFFFF.
  - 7/−2 -> LO=16'hFFFD, HI=1.
  - 16'h8000 / 16'hFFFF -> LO=16'h8000, HI=0.
